// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg -- shared definitions for the execute stage.
//   * Opcode encoding (5 bits) for single-cycle, branch and mul/div operations.
//   * Iterative-unit FSM state encoding (IDLE, MUL, DIV, DONE).
//   * Output bundle types and the bubble control constant.
//   * is_muldiv(): true for opcodes handled by the iterative unit.
// -----------------------------------------------------------------------------
package exec_pkg;

  localparam int unsigned XLEN = 64;

  // Single-cycle ALU operations
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  // Branch compares (rs1_val vs rs2_val)
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_BNE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12;
  localparam logic [4:0] OP_BGE  = 5'd13;
  localparam logic [4:0] OP_BLTU = 5'd14;
  localparam logic [4:0] OP_BGEU = 5'd15;
  // Iterative operations (contiguous range, see is_muldiv)
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_DIV  = 5'd17;
  localparam logic [4:0] OP_DIVU = 5'd18;
  localparam logic [4:0] OP_REM  = 5'd19;
  localparam logic [4:0] OP_REMU = 5'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } exec_state_e;

  // Fields a bubble forces to zero; everything else in exec_out_t holds.
  typedef struct packed {
    logic [4:0] rd;
    logic       write_back;
    logic       mem_en;
    logic       branch_flag;
  } exec_ctrl_t;

  localparam exec_ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    exec_ctrl_t      ctrl;
    logic            load;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] branch_offset;
  } exec_out_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- 1-bit-per-cycle multiplier / restoring divider.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : load operands and begin (only sampled in IDLE)
//   hold            : freeze FSM, counter and datapath
//   abort           : return to IDLE immediately (wins over hold)
//   op, a, b        : opcode (MUL/DIV/DIVU/REM/REMU) and operands
//   busy            : FSM not in IDLE
//   done            : single-cycle strobe on the DONE->IDLE edge
//   result          : final value, valid while in DONE
// Timing: start edge -> MUL/DIV, 64 iterations, -> DONE, -> IDLE.
// -----------------------------------------------------------------------------
module muldiv_iter
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  input  logic            abort,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  exec_state_e     state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  // acc: product (MUL) or partial remainder (DIV)
  // opa: shifting multiplicand (MUL) or divisor magnitude (DIV)
  // opb: shifting multiplier (MUL) or dividend-in / quotient-out (DIV)
  logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic            is_mul_q, is_mul_d, want_rem_q, want_rem_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic [XLEN:0]   r_sh, diff;
  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] quo, rem;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    is_mul_d   = is_mul_q;
    want_rem_d = want_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;

    r_sh      = {acc_q, opb_q[XLEN-1]};
    diff      = r_sh - {1'b0, opa_q};
    is_signed = (op == OP_DIV) || (op == OP_REM);
    a_neg     = is_signed & a[XLEN-1];
    b_neg     = is_signed & b[XLEN-1];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = '0;
          acc_d      = '0;
          is_mul_d   = (op == OP_MUL);
          want_rem_d = (op == OP_REM) || (op == OP_REMU);
          if (op == OP_MUL) begin
            state_d = MUL;
            opa_d   = a;
            opb_d   = b;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else begin
            state_d = DIV;
            opb_d   = a_neg ? -a : a;
            opa_d   = b_neg ? -b : b;
            // Divide by zero: the unsigned loop already yields all-ones
            // quotient and |dividend| remainder; only the remainder takes
            // the dividend's sign, the quotient must stay all ones.
            q_neg_d = (a_neg ^ b_neg) & (b != '0);
            r_neg_d = a_neg;
          end
        end
      end
      MUL: begin
        if (!hold) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = DONE;
        end
      end
      DIV: begin
        if (!hold) begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            opb_d = {opb_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = r_sh[XLEN-1:0];
            opb_d = {opb_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = DONE;
        end
      end
      DONE: begin
        if (!hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the datapath has no reset; start always reloads it before any
  // result is taken from it, and busy/done come only from state_q.
  always_ff @(posedge clk) begin
    acc_q      <= acc_d;
    opa_q      <= opa_d;
    opb_q      <= opb_d;
    is_mul_q   <= is_mul_d;
    want_rem_q <= want_rem_d;
    q_neg_q    <= q_neg_d;
    r_neg_q    <= r_neg_d;
  end

  assign quo    = q_neg_q ? -opb_q : opb_q;
  assign rem    = r_neg_q ? -acc_q : acc_q;
  assign result = is_mul_q ? acc_q : (want_rem_q ? rem : quo);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) & ~hold & ~abort;

endmodule

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage -- pipeline execute stage.
//   CLK, RST_N        : clock, synchronous active-low reset
//   EN, stall, flush  : valid from decode, downstream hold, branch flush
//   op, rs1_val, rs2_val, imm, use_imm : operation and operands (B = imm if use_imm)
//   rd_i, write_back_i, load_i, store_i, branch_flag_i, branch_offset_i : metadata
//   alu_res, address, value, LOAD, mem_en : result and memory request
//   rd_o, write_back, branch_flag_o, branch_offset_o : forwarded metadata
//   busy              : iterative op in flight, upstream must hold
// Build option: define EXEC_MULDIV_EN to enable MUL/DIV/DIVU/REM/REMU through
// muldiv_iter; otherwise those opcodes produce a bubble and busy is 0.
// Priority per edge: reset > flush > stall > mul/div completion > accept.
// -----------------------------------------------------------------------------
module exec_stage
  import exec_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  input  logic            stall,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [4:0]      rd_i,
  input  logic            write_back_i,
  input  logic            load_i,
  input  logic            store_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_offset_i,
  output logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] address,
  output logic [XLEN-1:0] value,
  output logic            LOAD,
  output logic            mem_en,
  output logic [4:0]      rd_o,
  output logic            write_back,
  output logic            branch_flag_o,
  output logic [XLEN-1:0] branch_offset_o,
  output logic            busy
);

  exec_out_t       out_q, out_d, new_out;
  logic [XLEN-1:0] op_b, alu_val;
  logic            accept, md_busy;

  assign op_b   = use_imm ? imm : rs2_val;
  assign accept = EN & ~md_busy & ~stall & ~flush;

  always_comb begin
    alu_val = '0;
    case (op)
      OP_ADD:  alu_val = rs1_val + op_b;
      OP_SUB:  alu_val = rs1_val - op_b;
      OP_AND:  alu_val = rs1_val & op_b;
      OP_OR:   alu_val = rs1_val | op_b;
      OP_XOR:  alu_val = rs1_val ^ op_b;
      OP_SLL:  alu_val = rs1_val << op_b[5:0];
      OP_SRL:  alu_val = rs1_val >> op_b[5:0];
      OP_SRA:  alu_val = $signed(rs1_val) >>> op_b[5:0];
      OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      OP_BEQ:  alu_val = {{(XLEN-1){1'b0}}, rs1_val == rs2_val};
      OP_BNE:  alu_val = {{(XLEN-1){1'b0}}, rs1_val != rs2_val};
      OP_BLT:  alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
      OP_BGE:  alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_val) >= $signed(rs2_val)};
      OP_BLTU: alu_val = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
      OP_BGEU: alu_val = {{(XLEN-1){1'b0}}, rs1_val >= rs2_val};
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    new_out                  = '0;
    new_out.ctrl.rd          = rd_i;
    new_out.ctrl.write_back  = write_back_i & (rd_i != 5'd0);
    new_out.ctrl.mem_en      = load_i | store_i;
    new_out.ctrl.branch_flag = branch_flag_i;
    new_out.load             = load_i;
    new_out.alu_res          = alu_val;
    new_out.address          = rs1_val + imm;
    new_out.value            = rs2_val;
    new_out.branch_offset    = branch_offset_i;
  end

`ifdef EXEC_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;
  exec_out_t       pend_q, pend_d;

  muldiv_iter u_muldiv (
    .clk    (CLK),
    .rst_n  (RST_N),
    .start  (accept & is_muldiv(op)),
    .hold   (stall),
    .abort  (flush),
    .op     (op),
    .a      (rs1_val),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Metadata of the in-flight mul/div, released together with its result.
  always_comb begin
    pend_d = pend_q;
    if (accept && is_muldiv(op)) pend_d = new_out;
  end

  always_ff @(posedge CLK) begin
    pend_q <= pend_d;
  end
`else
  assign md_busy = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d.ctrl = BUBBLE_CTRL;
    end else if (stall) begin
      out_d = out_q;
`ifdef EXEC_MULDIV_EN
    end else if (md_done) begin
      out_d         = pend_q;
      out_d.alu_res = md_result;
`endif
    end else if (accept && !is_muldiv(op)) begin
      out_d = new_out;
    end else begin
      // EN low, op in flight, or a mul/div just accepted (or unsupported).
      out_d.ctrl = BUBBLE_CTRL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) out_q <= '0;
    else        out_q <= out_d;
  end

  assign alu_res         = out_q.alu_res;
  assign address         = out_q.address;
  assign value           = out_q.value;
  assign LOAD            = out_q.load;
  assign mem_en          = out_q.ctrl.mem_en;
  assign rd_o            = out_q.ctrl.rd;
  assign write_back      = out_q.ctrl.write_back;
  assign branch_flag_o   = out_q.ctrl.branch_flag;
  assign branch_offset_o = out_q.branch_offset;
  assign busy            = md_busy;

endmodule
